// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin subtractor, LSB first, one full-subtractor cell.
// Ports: clk/rst_n, in_valid/in_ready+A/B/Bin, out_valid/out_ready+Diff/Bout/Ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dsh;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br;
  logic             w_last;
  logic [WIDTH-1:0] w_dsh;

  assign w_a    = r_a[0];
  assign w_b    = r_b[0];
  assign w_d    = w_a ^ w_b ^ r_br;
  assign w_br   = (~w_a & w_b) | (~w_a & r_br) | (w_b & r_br);
  assign w_last = (r_cnt == LAST);
  assign w_dsh  = {w_d, r_dsh[WIDTH-1:1]};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Diff      = r_diff;
  assign Bout      = r_bout;
  assign Ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // On the last bit, operand regs hold the msbs in bit 0,
  // and the freshly computed d is the result msb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_dsh  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
            r_dsh <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br;
          r_dsh <= w_dsh;
          if (w_last) begin
            r_diff <= w_dsh;
            r_bout <= w_br;
            r_ovf  <= (w_a ^ w_b) & (w_a ^ w_d);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
